dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory between the core's MEM stage and a debug/loader port (memory preload, result dump, DMA).
- Core has priority. A bounded-wait counter guarantees debug forward progress.
- Read data returns one cycle after grant, routed to whichever port owned the read.
- Sits between the core / debug master and the data memory instance.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Core/debug arbiter for the single-ported data memory. The core has
//            priority, and a bounded wait force-grants debug.
//            Optional macro DMEM_ARB_PERF_EN adds the PERF_CSTALL/PERF_DGNT counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              C_REQ,
  input  logic [3:0]        C_WSTB,
  input  logic [ADDR_W-1:0] C_ADDR,
  input  logic [31:0]       C_WDATA,
  output logic              C_STALL,
  output logic [31:0]       C_RDATA,
  output logic              C_RVALID,
  input  logic              D_REQ,
  input  logic [3:0]        D_WSTB,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic [31:0]       D_RDATA,
  output logic              D_RVALID,
  output logic              M_REN,
  output logic [3:0]        M_WSTB,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  input  logic [31:0]       M_RDATA
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       PERF_CSTALL,
  output logic [31:0]       PERF_DGNT
`endif
);

  typedef enum logic [0:0] {
    ST_CORE_PRI  = 1'b0,
    ST_DBG_FORCE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

  state_t     r_state;
  owner_t     r_rd_owner;
  logic [7:0] r_wait_cnt;

  logic w_c_req;
  logic w_d_req;
  logic w_c_gnt;
  logic w_d_gnt;

  // Requests are masked while reset is held so every combinational output idles.
  assign w_c_req = C_REQ & RSTN;
  assign w_d_req = D_REQ & RSTN;
  assign w_c_gnt = w_c_req & ((r_state == ST_CORE_PRI) | ~w_d_req);
  assign w_d_gnt = w_d_req & ((r_state == ST_DBG_FORCE) | ~w_c_req);

  assign C_STALL  = w_c_req & ~w_c_gnt;
  assign D_GNT    = w_d_gnt;
  assign C_RDATA  = M_RDATA;
  assign D_RDATA  = M_RDATA;
  assign C_RVALID = (r_rd_owner == OWN_CORE);
  assign D_RVALID = (r_rd_owner == OWN_DBG);

  always_comb begin
    M_REN   = 1'b0;
    M_WSTB  = 4'b0000;
    M_ADDR  = '0;
    M_WDATA = 32'h0;
    if (w_c_gnt) begin
      M_REN   = (C_WSTB == 4'b0000);
      M_WSTB  = C_WSTB;
      M_ADDR  = C_ADDR;
      M_WDATA = C_WDATA;
    end else if (w_d_gnt) begin
      M_REN   = (D_WSTB == 4'b0000);
      M_WSTB  = D_WSTB;
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= ST_CORE_PRI;
      r_wait_cnt <= 8'd0;
      r_rd_owner <= OWN_NONE;
    end else begin
      case (r_state)
        ST_CORE_PRI: begin
          // Debug lost this cycle; after MAX_WAIT straight losses it gets one forced slot.
          if (w_d_req & w_c_req) begin
            if (r_wait_cnt == c_wait_last) begin
              r_state    <= ST_DBG_FORCE;
              r_wait_cnt <= 8'd0;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end else begin
            r_wait_cnt <= 8'd0;
          end
        end
        ST_DBG_FORCE: begin
          r_state    <= ST_CORE_PRI;
          r_wait_cnt <= 8'd0;
        end
        default: begin
          r_state    <= ST_CORE_PRI;
          r_wait_cnt <= 8'd0;
        end
      endcase

      if (w_c_gnt && (C_WSTB == 4'b0000))
        r_rd_owner <= OWN_CORE;
      else if (w_d_gnt && (D_WSTB == 4'b0000))
        r_rd_owner <= OWN_DBG;
      else
        r_rd_owner <= OWN_NONE;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_cstall;
  logic [31:0] r_perf_dgnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_perf_cstall <= 32'h0;
      r_perf_dgnt   <= 32'h0;
    end else begin
      if (C_STALL && (r_perf_cstall != 32'hFFFF_FFFF))
        r_perf_cstall <= r_perf_cstall + 32'd1;
      if (D_GNT && (r_perf_dgnt != 32'hFFFF_FFFF))
        r_perf_dgnt <= r_perf_dgnt + 32'd1;
    end
  end

  assign PERF_CSTALL = r_perf_cstall;
  assign PERF_DGNT   = r_perf_dgnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a reference model and a memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              C_REQ = 1'b0;
  logic [3:0]        C_WSTB = 4'h0;
  logic [ADDR_W-1:0] C_ADDR = '0;
  logic [31:0]       C_WDATA = 32'h0;
  logic              C_STALL;
  logic [31:0]       C_RDATA;
  logic              C_RVALID;
  logic              D_REQ = 1'b0;
  logic [3:0]        D_WSTB = 4'h0;
  logic [ADDR_W-1:0] D_ADDR = '0;
  logic [31:0]       D_WDATA = 32'h0;
  logic              D_GNT;
  logic [31:0]       D_RDATA;
  logic              D_RVALID;
  logic              M_REN;
  logic [3:0]        M_WSTB;
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_WDATA;
  logic [31:0]       M_RDATA = 32'h0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]       PERF_CSTALL;
  logic [31:0]       PERF_DGNT;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .C_REQ(C_REQ), .C_WSTB(C_WSTB), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
    .C_STALL(C_STALL), .C_RDATA(C_RDATA), .C_RVALID(C_RVALID),
    .D_REQ(D_REQ), .D_WSTB(D_WSTB), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RDATA(D_RDATA), .D_RVALID(D_RVALID),
    .M_REN(M_REN), .M_WSTB(M_WSTB), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_RDATA(M_RDATA)
`ifdef DMEM_ARB_PERF_EN
    , .PERF_CSTALL(PERF_CSTALL), .PERF_DGNT(PERF_DGNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Data memory: registered read, byte-strobed write.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (M_WSTB[b]) mem[M_ADDR][8*b +: 8] <= M_WDATA[8*b +: 8];
    if (M_REN) M_RDATA <= mem[M_ADDR];
  end

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A00_0000 ^ (a * 32'h9E37_79B1);
  endfunction

  // Reference model state
  typedef struct {
    int          due;
    bit          own_dbg;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [int];
  int          losses = 0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  int          exp_cstall = 0;
  int          exp_dgnt = 0;
  bit          last_cg = 1'b0;
  bit          last_dg = 1'b0;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic ref_wr(input int a, input logic [3:0] stb, input logic [31:0] d);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++)
      if (stb[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = v;
  endtask

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus: inputs are already driven; check at negedge, update model.
  task automatic step(input bit assert_rst);
    bit          cg = 1'b0;
    bit          dg = 1'b0;
    bit          forced;
    logic [53:0] exp_v;
    logic [53:0] act_v;
    @(negedge CLK);
    cyc++;
    forced = (losses >= MAX_WAIT);
    if (RSTN) begin
      if (forced) begin
        dg = D_REQ;
        cg = C_REQ && !D_REQ;
      end else begin
        cg = C_REQ;
        dg = D_REQ && !C_REQ;
      end
    end
    exp_v = '0;
    exp_v[53] = RSTN && C_REQ && !cg;
    exp_v[52] = dg;
    if (cg)      exp_v[51:0] = {C_WSTB == 4'h0, C_WSTB, C_ADDR, C_WDATA};
    else if (dg) exp_v[51:0] = {D_WSTB == 4'h0, D_WSTB, D_ADDR, D_WDATA};
    act_v = {C_STALL, D_GNT, M_REN, M_WSTB, M_ADDR, M_WDATA};
    chk(act_v === exp_v, "arb_outputs", 64'(act_v), 64'(exp_v));

    if (RSTN && !assert_rst) begin
      if (forced) losses = 0;
      else if (C_REQ && D_REQ) losses++;
      else losses = 0;
      if (exp_v[53]) exp_cstall++;
      if (dg) exp_dgnt++;
      if (cg) begin
        if (C_WSTB == 4'h0) q.push_back('{cyc + 1, 1'b0, ref_rd(int'(C_ADDR))});
        else ref_wr(int'(C_ADDR), C_WSTB, C_WDATA);
      end else if (dg) begin
        if (D_WSTB == 4'h0) q.push_back('{cyc + 1, 1'b1, ref_rd(int'(D_ADDR))});
        else ref_wr(int'(D_ADDR), D_WSTB, D_WDATA);
      end
    end else begin
      losses     = 0;
      exp_cstall = 0;
      exp_dgnt   = 0;
    end
    last_cg = cg;
    last_dg = dg;

    // Reset edges are moved clear of the monitor sample point.
    if (!RSTN) begin
      #3;
      RSTN  = 1'b1;
      C_REQ = 1'b0;
      D_REQ = 1'b0;
    end else if (assert_rst) begin
      #3;
      RSTN = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_c(input bit r, input logic [3:0] s, input int a, input logic [31:0] d);
    C_REQ = r; C_WSTB = s; C_ADDR = ADDR_W'(a); C_WDATA = d;
  endtask

  task automatic set_d(input bit r, input logic [3:0] s, input int a, input logic [31:0] d);
    D_REQ = r; D_WSTB = s; D_ADDR = ADDR_W'(a); D_WDATA = d;
  endtask

  // Monitor: read responses against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk({C_RVALID, D_RVALID} === (e.own_dbg ? 2'b01 : 2'b10), "rvalid_route",
            64'({C_RVALID, D_RVALID}), 64'(e.own_dbg ? 2'b01 : 2'b10));
        chk((e.own_dbg ? D_RDATA : C_RDATA) === e.data, "rdata",
            64'(e.own_dbg ? D_RDATA : C_RDATA), 64'(e.data));
      end else begin
        chk({C_RVALID, D_RVALID} === 2'b00, "rvalid_idle", 64'({C_RVALID, D_RVALID}), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    // Reset held with both requests asserted: everything must idle.
    @(posedge CLK); #1;
    set_c(1, 4'h0, 16, 32'h0);
    set_d(1, 4'h0, 2, 32'h0);
    step(0);
    set_c(0, 4'h0, 0, 0); set_d(0, 4'h0, 0, 0);
    step(0);

    // Core-only read of preloaded word.
    set_c(1, 4'h0, 16'h0010, 32'h0); step(0);
    set_c(0, 4'h0, 0, 0); step(0);

    // Debug partial write, then core reads it back.
    set_d(1, 4'b0011, 16'h0020, 32'h1234_5678); step(0);
    set_d(0, 4'h0, 0, 0);
    set_c(1, 4'h0, 16'h0020, 32'h0); step(0);
    set_c(0, 4'h0, 0, 0); step(0);

    // Alternating owners on successive cycles.
    set_c(1, 4'h0, 1, 0); step(0);
    set_c(0, 4'h0, 0, 0);
    set_d(1, 4'h0, 2, 0); step(0);
    set_d(0, 4'h0, 0, 0); step(0); step(0);

    // Continuous contention: debug wins once every MAX_WAIT+1 cycles.
    set_c(1, 4'h0, 3, 0);
    set_d(1, 4'h0, 4, 0);
    for (int i = 0; i < 10; i++) step(0);

    // Four more losses, then reset lands on the forced debug read.
    for (int i = 0; i < MAX_WAIT; i++) step(0);
    step(1);
    step(0);
    step(0);
    set_c(1, 4'h0, 5, 0);
    set_d(1, 4'h0, 6, 0);
    for (int i = 0; i < 7; i++) step(0);
    set_c(0, 4'h0, 0, 0); set_d(0, 4'h0, 0, 0); step(0);

    // Randomized traffic with legal hold behaviour.
    for (int n = 0; n < 500; n++) begin
      if (!(C_REQ && !last_cg)) begin
        set_c(($urandom % 10) < 6, (($urandom % 3) == 0) ? 4'($urandom) : 4'h0,
              int'($urandom_range(0, 15)), $urandom);
      end
      if (!(D_REQ && !last_dg && (($urandom % 8) != 0))) begin
        set_d(($urandom % 2) == 0, (($urandom % 3) == 0) ? 4'($urandom) : 4'h0,
              int'($urandom_range(0, 15)), $urandom);
      end
      step(0);
    end
    set_c(0, 4'h0, 0, 0); set_d(0, 4'h0, 0, 0);
    step(0); step(0);
    chk(q.size() == 0, "queue_drain", 64'(q.size()), 64'd0);

`ifdef DMEM_ARB_PERF_EN
    chk(PERF_CSTALL == 32'(exp_cstall), "perf_cstall", 64'(PERF_CSTALL), 64'(exp_cstall));
    chk(PERF_DGNT == 32'(exp_dgnt), "perf_dgnt", 64'(PERF_DGNT), 64'(exp_dgnt));
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
